// File: rtl/pmem_pkg.sv
// Shared definitions for the program-memory SFR port.
// Register select codes, CTRL bit positions and FSM state encodings.
package pmem_pkg;

    localparam logic [1:0] SEL_OFS_L = 2'd0;
    localparam logic [1:0] SEL_OFS_H = 2'd1;
    localparam logic [1:0] SEL_DATA  = 2'd2;
    localparam logic [1:0] SEL_CTRL  = 2'd3;

    localparam int CTRL_START   = 7;
    localparam int CTRL_BUSY    = 7;
    localparam int CTRL_ERR     = 6;
    localparam int CTRL_OVR     = 5;
    localparam int CTRL_AUTOINC = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RDW  = 2'd1,
        ST_WRP  = 2'd2,
        ST_WRW  = 2'd3
    } state_t;

endpackage

// File: rtl/pmem_sfr_port_if.sv
// CPU-side SFR bus of the program-memory port.
// The CPU is master; the port block is slave.
interface pmem_sfr_port_if;
    logic [1:0] sfr_sel;
    logic       sfr_we;
    logic       sfr_re;
    logic [7:0] sfr_wd;
    logic [7:0] sfr_rd;

    modport master (
        output sfr_sel, sfr_we, sfr_re, sfr_wd,
        input  sfr_rd
    );

    modport slave (
        input  sfr_sel, sfr_we, sfr_re, sfr_wd,
        output sfr_rd
    );
endinterface

// File: rtl/pmem_tmo_cnt.sv
// Access timeout counter: clear, enable, terminal count at all-ones.
// Used to abort a stalled controller handshake.
module pmem_tmo_cnt #(
    parameter int W = 12
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = &cnt;

endmodule

// File: rtl/pmem_sfr_port.sv
// SFR front-end for program-memory reads and writes via an
// external controller, with auto-increment and timeout abort.
module pmem_sfr_port
    import pmem_pkg::*;
#(
    parameter int BIT_ADDR = 15,
    parameter int TMO_W    = 12
) (
    input  logic                clk,
    input  logic                srst,
    pmem_sfr_port_if.slave      sfr,
    output logic [BIT_ADDR-1:0] psofs,
    output logic                psr,
    output logic                psw,
    output logic [7:0]          wdat,
    input  logic                psrack,
    input  logic                ofs_inc,
    input  logic [7:0]          d_inst,
    output logic                irq_done
);

    state_t state, state_n;
    logic [7:0] rdbuf;
    logic autoinc, err, ovr;
    logic busy, waiting, tc;
    logic wr_l, wr_h, wr_d, wr_c;
    logic rd_start, wr_start, ovr_set;
    logic done, tmo_hit;
    logic [7:0] ofs_h;
    logic re_unused;

    assign re_unused = sfr.sfr_re;

    assign busy    = (state != ST_IDLE);
    assign waiting = (state == ST_RDW) || (state == ST_WRW);

    assign wr_l = sfr.sfr_we && (sfr.sfr_sel == SEL_OFS_L);
    assign wr_h = sfr.sfr_we && (sfr.sfr_sel == SEL_OFS_H);
    assign wr_d = sfr.sfr_we && (sfr.sfr_sel == SEL_DATA);
    assign wr_c = sfr.sfr_we && (sfr.sfr_sel == SEL_CTRL);

    assign rd_start = wr_c && sfr.sfr_wd[CTRL_START] && !busy;
    assign wr_start = wr_d && !busy;
    assign ovr_set  = busy && (wr_l || wr_h || wr_d ||
                      (wr_c && sfr.sfr_wd[CTRL_START]));

    pmem_tmo_cnt #(.W(TMO_W)) u_tmo (
        .clk  (clk),
        .srst (srst),
        .clr  (!busy),
        .en   (waiting),
        .tc   (tc)
    );

    always_ff @(posedge clk) begin
        if (srst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // A real acknowledge beats a timeout landing in the same cycle.
    always_comb begin
        state_n = state;
        done    = 1'b0;
        tmo_hit = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (rd_start) begin
                    state_n = ST_RDW;
                end else if (wr_start) begin
                    state_n = ST_WRP;
                end
            end
            ST_RDW: begin
                if (psrack) begin
                    done    = 1'b1;
                    state_n = ST_IDLE;
                end else if (tc) begin
                    tmo_hit = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_WRP: begin
                state_n = ST_WRW;
            end
            ST_WRW: begin
                if (ofs_inc) begin
                    done    = 1'b1;
                    state_n = ST_IDLE;
                end else if (tc) begin
                    tmo_hit = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign psr = (state == ST_RDW);
    assign psw = (state == ST_WRP);

    always_ff @(posedge clk) begin
        if (srst) begin
            psofs    <= '0;
            wdat     <= 8'h00;
            rdbuf    <= 8'h00;
            autoinc  <= 1'b0;
            err      <= 1'b0;
            ovr      <= 1'b0;
            irq_done <= 1'b0;
        end else begin
            irq_done <= done || tmo_hit;
            // Accepted offset writes win over auto-increment.
            if (wr_l && !busy) begin
                psofs[7:0] <= sfr.sfr_wd;
            end else if (wr_h && !busy) begin
                psofs[BIT_ADDR-1:8] <= sfr.sfr_wd[BIT_ADDR-9:0];
            end else if (autoinc && ofs_inc) begin
                psofs <= psofs + 1'b1;
            end
            if (wr_start) begin
                wdat <= sfr.sfr_wd;
            end
            if ((state == ST_RDW) && psrack) begin
                rdbuf <= d_inst;
            end
            if (wr_c) begin
                autoinc <= sfr.sfr_wd[CTRL_AUTOINC];
            end
            if (tmo_hit) begin
                err <= 1'b1;
            end else if (wr_c && sfr.sfr_wd[CTRL_ERR]) begin
                err <= 1'b0;
            end
            if (ovr_set) begin
                ovr <= 1'b1;
            end else if (wr_c && sfr.sfr_wd[CTRL_OVR]) begin
                ovr <= 1'b0;
            end
        end
    end

    assign ofs_h = 8'(psofs >> 8);

    always_comb begin
        sfr.sfr_rd = 8'h00;
        unique case (sfr.sfr_sel)
            SEL_OFS_L: sfr.sfr_rd = psofs[7:0];
            SEL_OFS_H: sfr.sfr_rd = ofs_h;
            SEL_DATA:  sfr.sfr_rd = rdbuf;
            SEL_CTRL:  sfr.sfr_rd = {busy, err, ovr, 4'h0, autoinc};
            default:   sfr.sfr_rd = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_pmem_sfr_port.sv
// Scoreboard bench for pmem_sfr_port: directed SFR accesses,
// expected reads and completion events queued for a monitor.
module tb_pmem_sfr_port;
    import pmem_pkg::*;

    logic clk = 1'b0;
    logic srst = 1'b1;
    always #5 clk = ~clk;

    pmem_sfr_port_if sif();

    logic [14:0] psofs;
    logic psr, psw, irq_done;
    logic psrack, ofs_inc;
    logic [7:0] wdat, d_inst;

    pmem_sfr_port #(.BIT_ADDR(15), .TMO_W(12)) dut (
        .clk      (clk),
        .srst     (srst),
        .sfr      (sif),
        .psofs    (psofs),
        .psr      (psr),
        .psw      (psw),
        .wdat     (wdat),
        .psrack   (psrack),
        .ofs_inc  (ofs_inc),
        .d_inst   (d_inst),
        .irq_done (irq_done)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  rd_q[$];
    string       rd_n[$];
    logic [16:0] irq_q[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sif.sfr_re) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got %h, want none", sif.sfr_rd);
            end else begin
                automatic logic [7:0] e = rd_q.pop_front();
                automatic string n = rd_n.pop_front();
                check(n, {24'h0, sif.sfr_rd}, {24'h0, e});
            end
        end
        if (irq_done) begin
            if (irq_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL irq_unexpected: got pulse, want none");
            end else begin
                automatic logic [16:0] e = irq_q.pop_front();
                check("irq_state", {15'h0, psr, psw, psofs}, {15'h0, e});
            end
        end
    end

    task automatic wr(input logic [1:0] sel, input logic [7:0] d);
        sif.sfr_sel = sel;
        sif.sfr_wd  = d;
        sif.sfr_we  = 1'b1;
        @(posedge clk); #1;
        sif.sfr_we  = 1'b0;
    endtask

    task automatic rd(input logic [1:0] sel, input logic [7:0] e,
                      input string n);
        rd_q.push_back(e);
        rd_n.push_back(n);
        sif.sfr_sel = sel;
        sif.sfr_re  = 1'b1;
        @(posedge clk); #1;
        sif.sfr_re  = 1'b0;
    endtask

    task automatic pulse_inc();
        ofs_inc = 1'b1;
        @(posedge clk); #1;
        ofs_inc = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pc;
        sif.sfr_sel = SEL_OFS_L;
        sif.sfr_we  = 1'b0;
        sif.sfr_re  = 1'b0;
        sif.sfr_wd  = 8'h00;
        psrack  = 1'b0;
        ofs_inc = 1'b0;
        d_inst  = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out", {psr, psw, irq_done, wdat, psofs}, 0);
        srst = 1'b0;
        rd(SEL_OFS_L, 8'h00, "rst_ofs_l");
        rd(SEL_OFS_H, 8'h00, "rst_ofs_h");
        rd(SEL_DATA,  8'h00, "rst_data");
        rd(SEL_CTRL,  8'h00, "rst_ctrl");

        // read access acknowledged in the 6th request cycle
        wr(SEL_OFS_L, 8'h34);
        wr(SEL_OFS_H, 8'h12);
        check("rd_psofs", psofs, 15'h1234);
        irq_q.push_back({2'b00, 15'h1234});
        wr(SEL_CTRL, 8'h80);
        pc = 0;
        for (int i = 1; i <= 9; i++) begin
            if (i == 6) begin
                psrack = 1'b1;
                d_inst = 8'hA5;
            end
            @(negedge clk);
            if (psr) pc++;
            @(posedge clk); #1;
            psrack = 1'b0;
            d_inst = 8'h00;
        end
        check("rd_psr_cycles", pc, 6);
        rd(SEL_DATA, 8'hA5, "rd_rdbuf");
        rd(SEL_CTRL, 8'h00, "rd_ctrl");

        // write access with auto-increment wrapping
        wr(SEL_CTRL, 8'h01);
        wr(SEL_OFS_L, 8'hFF);
        wr(SEL_OFS_H, 8'h7F);
        check("wr_psofs_pre", psofs, 15'h7FFF);
        rd(SEL_OFS_H, 8'h7F, "wr_ofs_h");
        irq_q.push_back({2'b00, 15'h0000});
        wr(SEL_DATA, 8'h3C);
        pc = 0;
        for (int i = 0; i < 204; i++) begin
            ofs_inc = (i == 200);
            @(negedge clk);
            if (psw) pc++;
            @(posedge clk); #1;
        end
        ofs_inc = 1'b0;
        check("wr_psw_cycles", pc, 1);
        check("wr_wdat", wdat, 8'h3C);
        check("wr_psofs_wrap", psofs, 15'h0000);
        rd(SEL_CTRL, 8'h01, "wr_ctrl");

        // writes while busy are dropped and flag overrun
        wr(SEL_CTRL, 8'h00);
        irq_q.push_back({2'b00, 15'h0000});
        wr(SEL_DATA, 8'h11);
        wr(SEL_OFS_L, 8'h55);
        rd(SEL_CTRL, 8'hA0, "ovr_busy_ctrl");
        pulse_inc();
        rd(SEL_CTRL, 8'h20, "ovr_ctrl");
        check("ovr_psofs", psofs, 15'h0000);
        check("ovr_wdat", wdat, 8'h11);
        wr(SEL_CTRL, 8'h20);
        rd(SEL_CTRL, 8'h00, "ovr_clr");

        // offset write beats auto-increment
        wr(SEL_CTRL, 8'h01);
        wr(SEL_OFS_L, 8'h20);
        pulse_inc();
        check("inc_idle", psofs, 15'h0021);
        sif.sfr_sel = SEL_OFS_L;
        sif.sfr_wd  = 8'h10;
        sif.sfr_we  = 1'b1;
        ofs_inc     = 1'b1;
        @(posedge clk); #1;
        sif.sfr_we  = 1'b0;
        ofs_inc     = 1'b0;
        rd(SEL_OFS_L, 8'h10, "prio_ofs_l");
        check("prio_psofs", psofs, 15'h0010);
        wr(SEL_CTRL, 8'h00);
        pulse_inc();
        check("noinc_psofs", psofs, 15'h0010);

        // read timeout
        irq_q.push_back({2'b00, 15'h0010});
        wr(SEL_CTRL, 8'h80);
        pc = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (!psr) break;
            pc++;
        end
        check("tmo_psr_cycles", {31'h0, (pc >= 4095 && pc <= 4096)}, 1);
        @(posedge clk); #1;
        rd(SEL_CTRL, 8'h40, "tmo_ctrl");
        rd(SEL_DATA, 8'hA5, "tmo_rdbuf");
        wr(SEL_CTRL, 8'h40);
        rd(SEL_CTRL, 8'h00, "tmo_clr");

        // reset in the middle of a read
        wr(SEL_CTRL, 8'h01);
        wr(SEL_OFS_L, 8'h77);
        wr(SEL_CTRL, 8'h81);
        repeat (3) @(posedge clk);
        #1;
        check("srst_pre_psr", psr, 1);
        srst = 1'b1;
        @(posedge clk); #1;
        check("srst_psr", {psr, psw}, 0);
        srst = 1'b0;
        check("srst_out", {wdat, psofs}, 0);
        rd(SEL_OFS_L, 8'h00, "srst_ofs_l");
        rd(SEL_DATA,  8'h00, "srst_data");
        rd(SEL_CTRL,  8'h00, "srst_ctrl");
        repeat (4) @(posedge clk);
        #1;

        check("irq_q_left", irq_q.size(), 0);
        check("rd_q_left", rd_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmem_sfr_port.md
PMEM_SFR_PORT -- requirements
Module: pmem_sfr_port

Interface
REQ-001 SHALL have parameter BIT_ADDR, default 15, program-memory address width.
REQ-002 SHALL have parameter TMO_W, default 12, timeout counter width.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 srst  input  1  reset, synchronous, active-high.
REQ-005 sfr_sel  input  2  register select: 0 OFS_L, 1 OFS_H, 2 DATA, 3 CTRL.
REQ-006 sfr_we  input  1  SFR write strobe, 1T.
REQ-007 sfr_re  input  1  SFR read strobe, 1T.
REQ-008 sfr_wd  input  8  SFR write data.
REQ-009 sfr_rd  output  8  SFR read data, combinational from sfr_sel.
REQ-010 psofs  output  BIT_ADDR  program-memory offset to controller.
REQ-011 psr  output  1  read request level, held until psrack.
REQ-012 psw  output  1  write request, 1T pulse.
REQ-013 wdat  output  8  write byte to controller.
REQ-014 psrack  input  1  read acknowledge from controller.
REQ-015 ofs_inc  input  1  1T completion pulse from controller (read or write done).
REQ-016 d_inst  input  8  read byte from controller, valid when psrack=1.
REQ-017 irq_done  output  1  1T pulse on every access completion or abort.

Function
REQ-018 OFS_L/OFS_H SHALL form psofs = {OFS_H[BIT_ADDR-9:0],OFS_L}; unused OFS_H bits read 0.
REQ-019 CTRL read SHALL be {BUSY,ERR,OVR,4'h0,AUTOINC}; bit0 AUTOINC is R/W, ERR and OVR are cleared by writing CTRL with bit6 or bit5 set, respectively.
REQ-020 DATA read SHALL return RDBUF; DATA write in IDLE SHALL load wdat and start a write access.
REQ-021 CTRL write with bit7=1 in IDLE SHALL start a read access.
REQ-022 FSM states: IDLE, RDW, WRP, WRW; BUSY=1 in every state except IDLE.
REQ-023 IDLE->RDW on read start; psr=1 from the next cycle through the cycle psrack is sampled 1.
REQ-024 RDW: on psrack=1 SHALL capture d_inst into RDBUF, drop psr next cycle, pulse irq_done, go IDLE.
REQ-025 IDLE->WRP on write start; psw=1 for exactly the WRP cycle; WRP->WRW unconditionally.
REQ-026 WRW: on ofs_inc=1 SHALL pulse irq_done and go IDLE.
REQ-027 Timeout counter SHALL clear on leaving IDLE, increment each cycle in RDW/WRW; at all-ones SHALL set ERR, drop psr, pulse irq_done, go IDLE without updating RDBUF.
REQ-028 When AUTOINC=1, ofs_inc=1 SHALL increment psofs by 1 modulo 2**BIT_ADDR (all-ones wraps to 0); with AUTOINC=0 ofs_inc SHALL NOT alter psofs.
REQ-029 SFR writes to OFS_L/OFS_H/DATA or start commands while BUSY SHALL be ignored and set OVR; AUTOINC and clear bits remain writable while BUSY.
REQ-030 SFR write to OFS_L/OFS_H coincident with auto-increment SHALL take priority; no increment that cycle.
REQ-031 Simultaneous read and write start (CTRL write cannot coincide with DATA write) is impossible by select; sfr_re SHALL have no side effects.
REQ-032 ofs_inc or psrack received in IDLE SHALL be ignored except for REQ-028 increment.

Reset
REQ-033 On srst: state IDLE, psofs=0, wdat=0, RDBUF=8'h00, AUTOINC=0, ERR=0, OVR=0, counter 0, psr=0, psw=0, irq_done=0, effective the first rising edge with srst=1.
REQ-034 srst mid-access SHALL abort immediately: psr/psw low after that edge, no irq_done, no ERR.

Structure
REQ-035 Register select codes, CTRL bit positions, and FSM state encodings SHALL live in shared package pmem_pkg.
REQ-036 Timeout counter SHALL be a sub-module pmem_tmo_cnt (clear, enable, terminal-count output); all else flat.

Verification
REQ-037 Write OFS_L=8'h34, OFS_H=8'h12, CTRL=8'h80; return psrack with d_inst=8'hA5 after 6 cycles -> psofs=15'h1234, psr high 6 cycles, RDBUF=8'hA5, one irq_done.
REQ-038 AUTOINC=1, psofs=15'h7FFF, DATA=8'h3C, ofs_inc 200 cycles later -> psw one 1T pulse, wdat=8'h3C, psofs=15'h0000.
REQ-039 Read start, psrack never returned -> ERR=1 after 4095 cycles in RDW, psr low, RDBUF unchanged, BUSY=0.
REQ-040 Write OFS_L=8'h55 during WRW -> psofs unchanged, OVR=1; CTRL write 8'h20 -> OVR=0.
REQ-041 AUTOINC=1, OFS_L write 8'h10 same cycle as ofs_inc -> OFS_L=8'h10.
REQ-042 srst asserted in RDW -> psr=0 next edge, all registers at reset values, no irq_done.
